// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the uart receive-side blocks
//   RX_FIFO_DEPTH_LOG2 : default receive FIFO depth exponent
//   RX_FIFO_*          : receive capture FSM state encodings
package uart_pkg;
    localparam int RX_FIFO_DEPTH_LOG2 = 4;
    localparam logic [1:0] RX_FIFO_IDLE     = 2'd0;
    localparam logic [1:0] RX_FIFO_CAPTURE  = 2'd1;
    localparam logic [1:0] RX_FIFO_WAIT_LOW = 2'd2;
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: byte FIFO with registered first-word-fall-through head
//   cpu_clk, rst_n : clock, asynchronous active-low reset
//   push, wdata    : write request and byte (dropped when full unless popping)
//   pop            : advance head (ignored when empty)
//   rdata          : registered head byte, 0 when empty
//   count          : occupancy 0..2**DEPTH_LOG2
//   full, empty    : occupancy flags
import uart_pkg::*;

module sync_fifo #(
    parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
    input  logic                  cpu_clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [7:0]            wdata,
    input  logic                  pop,
    output logic [7:0]            rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic push_ok, pop_ok;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign pop_ok  = pop && !empty;
    // a pop in the same cycle frees the slot the push needs
    assign push_ok = push && (!full || pop_ok);
    assign wr_nxt  = wr_ptr + {{DEPTH_LOG2{1'b0}}, push_ok};
    assign rd_nxt  = rd_ptr + {{DEPTH_LOG2{1'b0}}, pop_ok};

    always_ff @(posedge cpu_clk) begin
        if (push_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end

    // head is preloaded with the entry that will be at rd_nxt, bypassing
    // the write port when that entry is the one being written this cycle
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            rdata  <= (rd_nxt == wr_nxt) ? 8'h00 :
                      (push_ok && rd_nxt == wr_ptr) ? wdata : mem[rd_nxt[DEPTH_LOG2-1:0]];
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers uart received bytes for CPU polling
//   cpu_clk, rst_n  : clock, asynchronous active-low reset
//   uart_get_recv   : uart receive-available flag (asynchronous)
//   uart_recv_data  : uart received byte, stable while uart_get_recv high
//   uart_recv_clear : one-cycle acknowledge pulse back to the uart
//   cpu_rd          : CPU read strobe, pops the head
//   cpu_data_out    : FIFO head, 0 when empty
//   cpu_data_av     : FIFO non-empty
//   cpu_count       : occupancy
//   overflow        : sticky byte-dropped flag, cleared by overflow_clr
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int DEPTH_LOG2  = RX_FIFO_DEPTH_LOG2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  cpu_clk,
    input  logic                  rst_n,
    input  logic                  uart_get_recv,
    input  logic [7:0]            uart_recv_data,
    output logic                  uart_recv_clear,
    input  logic                  cpu_rd,
    output logic [7:0]            cpu_data_out,
    output logic                  cpu_data_av,
    output logic [DEPTH_LOG2:0]   cpu_count,
    output logic                  overflow,
    input  logic                  overflow_clr
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0] state, state_nxt;
    logic av_s, push, full, empty, drop;

    assign av_s  = sync_q[SYNC_STAGES-1];
    assign push  = (state == RX_FIFO_IDLE) && av_s;
    // with the FIFO full, only a same-cycle read saves the byte
    assign drop  = push && full && !cpu_rd;
    assign cpu_data_av = !empty;

    // WAIT_LOW holds until the flag drops so one byte yields one push
    always_comb begin
        state_nxt = (state == RX_FIFO_IDLE)    ? (av_s ? RX_FIFO_CAPTURE : RX_FIFO_IDLE) :
                    (state == RX_FIFO_CAPTURE) ? RX_FIFO_WAIT_LOW :
                    (av_s ? RX_FIFO_WAIT_LOW : RX_FIFO_IDLE);
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q          <= '0;
            state           <= RX_FIFO_IDLE;
            uart_recv_clear <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            sync_q          <= {sync_q[SYNC_STAGES-2:0], uart_get_recv};
            state           <= state_nxt;
            uart_recv_clear <= push;
            overflow        <= drop || (overflow && !overflow_clr);
        end
    end

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .cpu_clk (cpu_clk),
        .rst_n   (rst_n),
        .push    (push),
        .wdata   (uart_recv_data),
        .pop     (cpu_rd),
        .rdata   (cpu_data_out),
        .count   (cpu_count),
        .full    (full),
        .empty   (empty)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    logic       cpu_clk = 0;
    logic       rst_n = 1;
    logic       uart_get_recv = 0;
    logic [7:0] uart_recv_data = 0;
    logic       uart_recv_clear;
    logic       cpu_rd = 0;
    logic [7:0] cpu_data_out;
    logic       cpu_data_av;
    logic [4:0] cpu_count;
    logic       overflow;
    logic       overflow_clr = 0;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    bit m_ovf = 0;

    typedef struct {
        bit         g;
        bit         rd;
        logic [7:0] d;
        bit         e_clr;
        bit         e_av;
        logic [7:0] e_data;
        int         e_cnt;
    } vec_t;
    vec_t tv[9];

    uart_rx_fifo dut (
        .cpu_clk         (cpu_clk),
        .rst_n           (rst_n),
        .uart_get_recv   (uart_get_recv),
        .uart_recv_data  (uart_recv_data),
        .uart_recv_clear (uart_recv_clear),
        .cpu_rd          (cpu_rd),
        .cpu_data_out    (cpu_data_out),
        .cpu_data_av     (cpu_data_av),
        .cpu_count       (cpu_count),
        .overflow        (overflow),
        .overflow_clr    (overflow_clr)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, " clear"}, uart_recv_clear, 0);
        chk({n, " av"}, cpu_data_av, 0);
        chk({n, " data"}, cpu_data_out, 0);
        chk({n, " count"}, cpu_count, 0);
        chk({n, " overflow"}, overflow, 0);
    endtask

    // one clock: drive inputs, advance, update queue model, compare
    task automatic step(input bit g, input logic [7:0] d, input bit rd, input bit oc, input bit p);
        bit set;
        uart_get_recv = g;
        uart_recv_data = d;
        cpu_rd = rd;
        overflow_clr = oc;
        @(posedge cpu_clk);
        #1;
        if (rd && q.size() > 0) void'(q.pop_front());
        set = p && q.size() == 16;
        if (p && !set) q.push_back(d);
        if (set) m_ovf = 1;
        else if (oc) m_ovf = 0;
        chk("clear", uart_recv_clear, p);
        chk("av", cpu_data_av, q.size() > 0);
        chk("data", cpu_data_out, q.size() > 0 ? q[0] : 8'h00);
        chk("count", cpu_count, q.size());
        chk("overflow", overflow, m_ovf);
    endtask

    // one byte from the uart: flag high for three edges, push at the third
    task automatic send(input logic [7:0] d, input bit [5:0] rdp, input bit [5:0] ocp);
        for (int i = 0; i < 6; i++) step(i < 3, d, rdp[i], ocp[i], i == 2);
    endtask

    task automatic do_reset();
        rst_n = 0;
        uart_get_recv = 0;
        cpu_rd = 0;
        overflow_clr = 0;
        #2;
        chk_zero("reset");
        q.delete();
        m_ovf = 0;
        @(posedge cpu_clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        tv[0] = '{1, 0, 8'h41, 0, 0, 8'h00, 0};
        tv[1] = '{1, 0, 8'h41, 0, 0, 8'h00, 0};
        tv[2] = '{1, 0, 8'h41, 1, 1, 8'h41, 1};
        tv[3] = '{0, 0, 8'h41, 0, 1, 8'h41, 1};
        tv[4] = '{0, 0, 8'h00, 0, 1, 8'h41, 1};
        tv[5] = '{0, 0, 8'h00, 0, 1, 8'h41, 1};
        tv[6] = '{0, 1, 8'h00, 0, 0, 8'h00, 0};
        tv[7] = '{0, 1, 8'h00, 0, 0, 8'h00, 0};
        tv[8] = '{0, 0, 8'h00, 0, 0, 8'h00, 0};
        #2;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            uart_get_recv = tv[i].g;
            uart_recv_data = tv[i].d;
            cpu_rd = tv[i].rd;
            @(posedge cpu_clk);
            #1;
            chk($sformatf("vec%0d clear", i), uart_recv_clear, tv[i].e_clr);
            chk($sformatf("vec%0d av", i), cpu_data_av, tv[i].e_av);
            chk($sformatf("vec%0d data", i), cpu_data_out, tv[i].e_data);
            chk($sformatf("vec%0d count", i), cpu_count, tv[i].e_cnt);
        end
        cpu_rd = 0;
        for (int b = 0; b < 16; b++) send(8'(b), 6'b0, 6'b0);
        chk("burst count", cpu_count, 16);
        send(8'hAA, 6'b0, 6'b0);
        chk("overflow set", overflow, 1);
        step(0, 8'h00, 0, 1, 0);
        chk("overflow cleared", overflow, 0);
        send(8'h55, 6'b000100, 6'b0);
        chk("full pop count", cpu_count, 16);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
        for (int k = 0; k < 40; k++) send(8'(8'h10 + k), 6'b010000, 6'b0);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                step(0, 8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 0);
            else
                send(8'($urandom), 6'($urandom & $urandom & $urandom), 6'($urandom & $urandom & $urandom & $urandom));
        end
        step(1, 8'h77, 0, 0, 0);
        step(1, 8'h77, 0, 0, 0);
        step(1, 8'h77, 0, 0, 1);
        #1;
        rst_n = 0;
        #1;
        chk_zero("mid-capture reset");
        q.delete();
        m_ovf = 0;
        @(posedge cpu_clk);
        #1;
        rst_n = 1;
        step(1, 8'h77, 0, 0, 0);
        step(1, 8'h77, 0, 0, 0);
        step(1, 8'h77, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 0, 0);
        chk("post-reset count", cpu_count, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
